// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use hazard detection and
// branch squash. It also keeps saturating counters for stall cycles and
// branch flushes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc4_in, instr_in    PC+4 and instruction word from fetch
//   id_ex_memread       MEMRead bit held in ID/EX
//   id_ex_rt            rt field held in ID/EX
//   branch_taken        redirect request; squashes the fetch and ID slots
//   pc4, instr, valid   registered decode-side view of the fetched word
//   pc_write            PC update enable to fetch (0 freezes the PC)
//   bubble              decode forces zero control into ID/EX
//   stall_cnt           saturating count of load-use stall cycles
//   flush_cnt           saturating count of branch flushes
//
// state | meaning
// RUN   | normal flow; a load-use hazard may stall
// STALL | one stall cycle has been taken; the hazard is ignored this cycle
// FLUSH | the ID slot was squashed by a branch; valid is 0
module if_id_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc4_in,
  input  logic [31:0]      instr_in,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken,
  output logic [31:0]      pc4,
  output logic [31:0]      instr,
  output logic             valid,
  output logic             pc_write,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [4:0] rs, rt;
  logic       hazard;
  logic       do_stall;

  assign rs = instr[25:21];
  assign rt = instr[20:16];

  // A zero destination register never creates a dependency.
  assign hazard = valid & id_ex_memread & (id_ex_rt != 5'd0) &
                  ((id_ex_rt == rs) | (id_ex_rt == rt));

  always_comb begin
    state_nxt = RUN;
    pc_write  = 1'b1;
    bubble    = 1'b0;
    do_stall  = 1'b0;
    if (branch_taken) begin
      bubble    = 1'b1;
      state_nxt = FLUSH;
    end else if (hazard && (state == RUN)) begin
      // Only RUN can stall, so each load costs exactly one cycle.
      pc_write  = 1'b0;
      bubble    = 1'b1;
      do_stall  = 1'b1;
      state_nxt = STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc4       <= '0;
      instr     <= '0;
      valid     <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (branch_taken) begin
        pc4   <= pc4_in;
        instr <= '0;
        valid <= 1'b0;
        if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
      end else if (do_stall) begin
        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        pc4   <= pc4_in;
        instr <= instr_in;
        valid <= 1'b1;
      end
    end
  end

endmodule
